texture_scan_loader: RTL and testbench

// - Sequences writes into the texture-memory scan chain. The chain is clocked by two
//   non-overlapping phases (phi1, phi2), carries serial data, and commits on a latch strobe.
// - Two requesters share the chain through a round-robin arbiter:
//   - port 0: host/UART configuration path.
//   - port 1: bulk texture fill engine.
// - Each accepted request becomes one serial frame on the chain:

---
 rtl/texture_scan_loader.sv | 157 +++++++++++++++
 tb/tb_texture_scan_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/texture_scan_loader.sv
// Texture-memory scan-chain loader: two-port round-robin arbiter feeding a
// two-phase serial shifter that emits {1, addr, data} frames followed by a latch strobe.
module texture_scan_loader #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int PHI_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              sc_phi1,
  output logic              sc_phi2,
  output logic              sc_data,
  output logic              sc_latch,
  output logic              busy,
  output logic              done,
  output logic              done_id
);
  // state | meaning
  // IDLE  | waiting for a request; ready is offered to the granted port
  // SETUP | present next serial bit, both phases low
  // PHI1  | master phase high for PHI_CYCLES cycles
  // PHI2  | slave phase high for PHI_CYCLES cycles, then shift or finish
  // LATCH | one-cycle commit strobe and done pulse

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int PH_W    = (PHI_CYCLES > 1) ? $clog2(PHI_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PHI1, S_PHI2, S_LATCH} state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]      ph_cnt_q, ph_cnt_d;
  logic                 last_grant_q, last_grant_d;
  logic                 owner_q, owner_d;
  logic                 sc_phi1_q, sc_phi1_d;
  logic                 sc_phi2_q, sc_phi2_d;
  logic                 sc_data_q, sc_data_d;
  logic                 sc_latch_q, sc_latch_d;
  logic                 busy_q, busy_d;
  logic                 done_id_q, done_id_d;
  logic                 grant;
  logic                 hs;

  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  // ready is gated by rst_n so it also drops immediately while reset is held
  assign req0_ready = rst_n && (state_q == S_IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state_q == S_IDLE) && req1_valid &&  grant;
  assign hs         = req0_ready || req1_ready;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ph_cnt_d     = ph_cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          shift_d      = grant ? {1'b1, req1_addr, req1_data} : {1'b1, req0_addr, req0_data};
          bit_cnt_d    = CNT_W'(FRAME_W - 1);
          last_grant_d = grant;
          owner_d      = grant;
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        ph_cnt_d = PH_W'(PHI_CYCLES - 1);
        state_d  = S_PHI1;
      end
      S_PHI1: begin
        if (ph_cnt_q == '0) begin
          ph_cnt_d = PH_W'(PHI_CYCLES - 1);
          state_d  = S_PHI2;
        end else begin
          ph_cnt_d = ph_cnt_q - PH_W'(1);
        end
      end
      S_PHI2: begin
        if (ph_cnt_q != '0) begin
          ph_cnt_d = ph_cnt_q - PH_W'(1);
        end else if (bit_cnt_q == '0) begin
          state_d = S_LATCH;
        end else begin
          shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
          state_d   = S_SETUP;
        end
      end
      S_LATCH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state so they are flops aligned with state_q
  always_comb begin
    sc_phi1_d  = (state_d == S_PHI1);
    sc_phi2_d  = (state_d == S_PHI2);
    sc_latch_d = (state_d == S_LATCH);
    busy_d     = (state_d != S_IDLE);
    sc_data_d  = busy_d ? shift_d[FRAME_W-1] : 1'b0;
    done_id_d  = sc_latch_d ? owner_d : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      ph_cnt_q     <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      sc_phi1_q    <= 1'b0;
      sc_phi2_q    <= 1'b0;
      sc_data_q    <= 1'b0;
      sc_latch_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      ph_cnt_q     <= ph_cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      sc_phi1_q    <= sc_phi1_d;
      sc_phi2_q    <= sc_phi2_d;
      sc_data_q    <= sc_data_d;
      sc_latch_q   <= sc_latch_d;
      busy_q       <= busy_d;
      done_id_q    <= done_id_d;
    end
  end

  assign sc_phi1  = sc_phi1_q;
  assign sc_phi2  = sc_phi2_q;
  assign sc_data  = sc_data_q;
  assign sc_latch = sc_latch_q;
  assign done     = sc_latch_q;
  assign busy     = busy_q;
  assign done_id  = done_id_q;

endmodule

// File: tb/tb_texture_scan_loader.sv
// Directed bench for texture_scan_loader: frame decode, arbitration, phase timing,
// mid-frame reset and a shadow scan-chain memory fill.
module tb_texture_scan_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v0, v1, rdy0, rdy1;
  logic [10:0] a0, a1;
  logic [7:0]  d0, d1;
  logic        phi1, phi2, sdat, latch, busy, done, did;

  logic        t_v0, t_v1, t_rdy0, t_rdy1;
  logic [10:0] t_a0, t_a1;
  logic [7:0]  t_d0, t_d1;
  logic        t_phi1, t_phi2, t_sdat, t_latch, t_busy, t_done, t_did;

  texture_scan_loader #(.ADDR_W(11), .DATA_W(8), .PHI_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1),
    .sc_phi1(phi1), .sc_phi2(phi2), .sc_data(sdat), .sc_latch(latch),
    .busy(busy), .done(done), .done_id(did));

  texture_scan_loader #(.ADDR_W(11), .DATA_W(8), .PHI_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t_v0), .req0_addr(t_a0), .req0_data(t_d0), .req0_ready(t_rdy0),
    .req1_valid(t_v1), .req1_addr(t_a1), .req1_data(t_d1), .req1_ready(t_rdy1),
    .sc_phi1(t_phi1), .sc_phi2(t_phi2), .sc_data(t_sdat), .sc_latch(t_latch),
    .busy(t_busy), .done(t_done), .done_id(t_did));

  logic sel3 = 1'b0;
  logic m_phi1, m_phi2, m_data, m_latch, m_busy, m_done, m_did;
  assign m_phi1  = sel3 ? t_phi1  : phi1;
  assign m_phi2  = sel3 ? t_phi2  : phi2;
  assign m_data  = sel3 ? t_sdat  : sdat;
  assign m_latch = sel3 ? t_latch : latch;
  assign m_busy  = sel3 ? t_busy  : busy;
  assign m_done  = sel3 ? t_done  : done;
  assign m_did   = sel3 ? t_did   : did;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Follows one frame from cycle 1 (SETUP) to the first IDLE cycle, decoding bits on phi1 rise.
  task automatic collect(output logic [19:0] bits, output int lat, output int nl,
                         output logic id, output int viol);
    logic pp1, pp2, pd, fin;
    int r1, r2, plen;
    plen = sel3 ? 3 : 1;
    bits = '0; lat = 0; nl = 0; id = 1'b0; viol = 0; fin = 1'b0;
    pp1 = 1'b0; pp2 = 1'b0; pd = m_data; r1 = 0; r2 = 0;
    for (int c = 1; c <= 400; c++) begin
      if (!m_busy) begin fin = 1'b1; break; end
      if (m_phi1 && !pp1) bits = {bits[18:0], m_data};
      if (m_phi1 && m_phi2) viol++;
      if ((m_phi1 || m_phi2) && (m_data !== pd)) viol++;
      if (m_done !== m_latch) viol++;
      if (m_phi1) r1++; else begin if (pp1 && r1 != plen) viol++; r1 = 0; end
      if (m_phi2) r2++; else begin if (pp2 && r2 != plen) viol++; r2 = 0; end
      if (m_latch) begin nl++; lat = c; id = m_did; end
      pp1 = m_phi1; pp2 = m_phi2; pd = m_data;
      @(negedge clk);
    end
    if (!fin) viol++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        port;
    logic [10:0] addr;
    logic [7:0]  data;
    logic [19:0] bits;
  } vec_t;
  vec_t vt[5];

  // shadow scan chain: shifts on phi1 rise, writes memory on latch
  logic        shadow_en = 1'b0;
  logic [19:0] sh_sr;
  logic        sh_prev;
  int          sh_bits, sh_frames, sh_bad;
  logic [8:0]  sh_mem [2048];
  logic [8:0]  exp_mem [2048];

  always @(negedge clk) begin
    sh_prev <= phi1;
    if (!shadow_en) begin
      for (int k = 0; k < 2048; k++) sh_mem[k] <= '0;
      sh_bits <= 0; sh_frames <= 0; sh_bad <= 0; sh_sr <= '0;
    end else begin
      if (phi1 && !sh_prev) begin
        sh_sr   <= {sh_sr[18:0], sdat};
        sh_bits <= sh_bits + 1;
      end
      if (latch) begin
        sh_frames <= sh_frames + 1;
        sh_bits   <= 0;
        if (sh_bits != 20 || sh_sr[19] !== 1'b1 || sh_mem[sh_sr[18:8]][8]) sh_bad <= sh_bad + 1;
        sh_mem[sh_sr[18:8]] <= {1'b1, sh_sr[7:0]};
      end
    end
  end

  initial begin
    logic [19:0] bits;
    int lat, nl, viol, bad, tmo;
    logic id;

    vt[0] = '{1'b0, 11'h5A3, 8'hC6, 20'b1_10110100011_11000110};
    vt[1] = '{1'b1, 11'h000, 8'h00, 20'b1_00000000000_00000000};
    vt[2] = '{1'b0, 11'h7FF, 8'hFF, 20'b1_11111111111_11111111};
    vt[3] = '{1'b1, 11'h001, 8'h80, 20'b1_00000000001_10000000};
    vt[4] = '{1'b0, 11'h400, 8'h01, 20'b1_10000000000_00000001};

    rst_n = 1'b0;
    v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    t_v0 = 0; t_v1 = 0; t_a0 = '0; t_a1 = '0; t_d0 = '0; t_d1 = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {rdy0, rdy1, phi1, phi2, sdat, latch, busy, done, did}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle outputs", {rdy0, rdy1, phi1, phi2, sdat, latch, busy, done, did}, 0);

    // single-port frames from the table
    for (int i = 0; i < 5; i++) begin
      if (vt[i].port) begin v1 = 1; a1 = vt[i].addr; d1 = vt[i].data; end
      else            begin v0 = 1; a0 = vt[i].addr; d0 = vt[i].data; end
      #1;
      chk($sformatf("v%0d ready", i), {rdy1, rdy0}, vt[i].port ? 2'b10 : 2'b01);
      @(negedge clk);
      v0 = 0; v1 = 0;
      collect(bits, lat, nl, id, viol);
      chk($sformatf("v%0d bits", i), bits, vt[i].bits);
      chk($sformatf("v%0d latch cycle", i), lat, 61);
      chk($sformatf("v%0d latch count", i), nl, 1);
      chk($sformatf("v%0d done_id", i), id, vt[i].port);
      chk($sformatf("v%0d phase viol", i), viol, 0);
    end

    // both ports valid: strict alternation, one IDLE cycle between frames
    do_reset();
    v0 = 1; a0 = 11'h123; d0 = 8'h45;
    v1 = 1; a1 = 11'h6DB; d1 = 8'hA9;
    for (int f = 0; f < 4; f++) begin
      #1;
      chk($sformatf("rr%0d ready", f), {rdy1, rdy0}, (f % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
      chk($sformatf("rr%0d busy", f), busy, 1);
      collect(bits, lat, nl, id, viol);
      chk($sformatf("rr%0d bits", f), bits,
          (f % 2) ? 20'b1_11011011011_10101001 : 20'b1_00100100011_01000101);
      chk($sformatf("rr%0d done_id", f), id, f % 2);
      chk($sformatf("rr%0d latch cycle", f), lat, 61);
    end
    v0 = 0; v1 = 0;

    // PHI_CYCLES=3 instance
    sel3 = 1'b1;
    t_v0 = 1; t_a0 = 11'h7FF; t_d0 = 8'h00;
    #1;
    chk("p3 ready", t_rdy0, 1);
    @(negedge clk);
    t_v0 = 0;
    collect(bits, lat, nl, id, viol);
    chk("p3 bits", bits, 20'hFFF00);
    chk("p3 latch cycle", lat, 141);
    chk("p3 latch count", nl, 1);
    chk("p3 phase viol", viol, 0);
    sel3 = 1'b0;

    // port 1 arrives mid-frame and changes data before its grant
    do_reset();
    v0 = 1; a0 = 11'h0F0; d0 = 8'h0F;
    #1;
    chk("mid ready0", rdy0, 1);
    @(negedge clk);
    v0 = 0;
    fork
      begin
        repeat (9) @(negedge clk);
        v1 = 1; a1 = 11'h2AA; d1 = 8'h11;
        repeat (10) @(negedge clk);
        #1;
        chk("mid ready1 while busy", rdy1, 0);
        d1 = 8'h99;
      end
    join_none
    collect(bits, lat, nl, id, viol);
    chk("mid p0 bits", bits, 20'b1_00011110000_00001111);
    chk("mid p0 done_id", id, 0);
    #1;
    chk("mid ready1 after latch", rdy1, 1);
    @(negedge clk);
    v1 = 0;
    collect(bits, lat, nl, id, viol);
    chk("mid p1 bits", bits, 20'b1_01010101010_10011001);
    chk("mid p1 done_id", id, 1);
    chk("mid p1 latch cycle", lat, 61);

    // reset during PHI1 of bit 7
    do_reset();
    v0 = 1; a0 = 11'h5A3; d0 = 8'hC6;
    v1 = 1; a1 = 11'h001; d1 = 8'h80;
    #1;
    chk("rst ready0", rdy0, 1);
    @(negedge clk);
    repeat (22) @(negedge clk);
    chk("rst in phi1", {phi1, phi2}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("rst outputs async", {rdy0, rdy1, phi1, phi2, sdat, latch, busy, done, did}, 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if ({rdy0, rdy1, phi1, phi2, sdat, latch, busy, done, did} != 0) bad++;
    end
    chk("rst outputs held", bad, 0);
    rst_n = 1'b1;
    #1;
    chk("rst port0 priority", {rdy1, rdy0}, 2'b01);
    @(negedge clk);
    collect(bits, lat, nl, id, viol);
    chk("rst frame bits", bits, vt[0].bits);
    chk("rst frame done_id", id, 0);
    chk("rst frame latch cycle", lat, 61);
    #1;
    chk("rst next grant", {rdy1, rdy0}, 2'b10);
    v0 = 0; v1 = 0;

    // port 1 fill against the shadow chain model
    for (int k = 0; k < 2048; k++) exp_mem[k] = '0;
    shadow_en = 1'b1;
    @(negedge clk);
    tmo = 0;
    for (int i = 0; i < 512; i++) begin
      logic [10:0] ad;
      ad = 11'(i * 4 + (i % 4));
      a1 = ad; d1 = ad[7:0] ^ 8'h3C; v1 = 1;
      exp_mem[ad] = {1'b1, ad[7:0] ^ 8'h3C};
      #1;
      for (int w = 0; w < 200 && !rdy1; w++) begin
        @(negedge clk);
        #1;
      end
      if (!rdy1) tmo++;
      @(negedge clk);
    end
    v1 = 0;
    for (int w = 0; w < 200 && busy; w++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("fill timeouts", tmo, 0);
    chk("fill frames", sh_frames, 512);
    chk("fill frame errors", sh_bad, 0);
    bad = 0;
    for (int k = 0; k < 2048; k++) if (sh_mem[k] !== exp_mem[k]) bad++;
    chk("fill image", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
